// File: rtl/ov_cam_init_seq.sv
// OV13850 init-table sequencer: walks a 24-bit entry ROM and drives a fixed-frame I2C
// write engine, handling delay/end markers and generating the engine's bit-phase tick.
module ov_cam_init_seq #(
    parameter int unsigned TICK_DIV  = 250,
    parameter int unsigned MS_CYCLES = 100000,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned TMO_TICKS = 255
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              iic_clock_en,
    output logic [23:0]       iic_data,
    output logic              iic_enable,
    output logic              iic_start_xfer,
    input  logic              iic_xfer_done,
    output logic              busy,
    output logic              init_done,
    output logic              init_err,
    output logic [ADDR_W-1:0] wr_count
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DlyW  = $clog2(255 * MS_CYCLES + 1);
    localparam int unsigned TcRaw = $clog2(TMO_TICKS + 1);
    localparam int unsigned TcW   = (TcRaw > 3) ? TcRaw : 3;

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StArm, StWait, StGap, StDelay, StNext, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       data_q, data_d;
    logic              en_q, en_d;
    logic              sx_q, sx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic [TcW-1:0]    tc_q, tc_d;
    logic              tick;
    logic              is_end;
    logic              is_dly;

    assign tick   = (tick_q == TickW'(TICK_DIV - 1));
    assign is_end = (rom_data == 24'hFFFFFF);
    assign is_dly = (rom_data[23:8] == 16'hFFFE);

    assign tick_d = tick ? '0 : tick_q + TickW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = en_q;
        sx_d    = sx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        wr_d    = wr_q;
        dly_d   = dly_q;
        tc_d    = tc_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wr_d    = '0;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (is_end) begin
                    state_d = StDone;
                end else if (is_dly) begin
                    if (rom_data[7:0] == 8'd0) begin
                        state_d = StNext;
                    end else begin
                        dly_d   = DlyW'(rom_data[7:0]) * DlyW'(MS_CYCLES);
                        state_d = StDelay;
                    end
                end else begin
                    data_d  = rom_data;
                    en_d    = 1'b1;
                    sx_d    = 1'b1;
                    state_d = StArm;
                end
            end
            StArm: begin
                // Restart must span one engine tick so its bit counter is cleared.
                if (tick) begin
                    sx_d    = 1'b0;
                    tc_d    = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (iic_xfer_done) begin
                    wr_d    = wr_q + ADDR_W'(1);
                    en_d    = 1'b0;
                    tc_d    = '0;
                    state_d = StGap;
                end else if (tick) begin
                    if (tc_q == TcW'(TMO_TICKS - 1)) begin
                        err_d   = 1'b1;
                        en_d    = 1'b0;
                        state_d = StDone;
                    end else begin
                        tc_d = tc_q + TcW'(1);
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (tc_q == TcW'(3)) begin
                        state_d = StNext;
                    end else begin
                        tc_d = tc_q + TcW'(1);
                    end
                end
            end
            StDelay: begin
                dly_d = dly_q - DlyW'(1);
                if (dly_q <= DlyW'(1)) begin
                    dly_d   = '0;
                    state_d = StNext;
                end
            end
            StNext: begin
                if (addr_q == '1) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                done_d  = ~err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            tick_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            sx_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            dly_q   <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            sx_q    <= sx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            dly_q   <= dly_d;
            tc_q    <= tc_d;
        end
    end

    assign rom_addr       = addr_q;
    assign iic_clock_en   = tick;
    assign iic_data       = data_q;
    assign iic_enable     = en_q;
    assign iic_start_xfer = sx_q;
    assign busy           = busy_q;
    assign init_done      = done_q;
    assign init_err       = err_q;
    assign wr_count       = wr_q;

endmodule

// File: tb/tb_ov_cam_init_seq.sv
// Directed bench for ov_cam_init_seq: sync ROM model plus a minimal I2C engine that
// answers each frame with xfer_done a fixed number of ticks after the restart drops.
module tb_ov_cam_init_seq;

    localparam int unsigned AW = 2;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic          iic_clock_en;
    logic [23:0]   iic_data;
    logic          iic_enable;
    logic          iic_start_xfer;
    logic          iic_xfer_done;
    logic          busy;
    logic          init_done;
    logic          init_err;
    logic [AW-1:0] wr_count;

    ov_cam_init_seq #(
        .TICK_DIV (4),
        .MS_CYCLES(100),
        .ADDR_W   (AW),
        .TMO_TICKS(255)
    ) dut (
        .clock_in      (clock_in),
        .reset_in      (reset_in),
        .start         (start),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .iic_clock_en  (iic_clock_en),
        .iic_data      (iic_data),
        .iic_enable    (iic_enable),
        .iic_start_xfer(iic_start_xfer),
        .iic_xfer_done (iic_xfer_done),
        .busy          (busy),
        .init_done     (init_done),
        .init_err      (init_err),
        .wr_count      (wr_count)
    );

    always #5 clock_in = ~clock_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] mem [4];
    always @(posedge clock_in) rom_data <= mem[rom_addr];

    // Engine model: done pulses on the 6th tick after restart release.
    logic     mute = 1'b0;
    int       ecnt = 0;
    initial   iic_xfer_done = 1'b0;
    always @(posedge clock_in) begin
        cyc <= cyc + 1;
        iic_xfer_done <= 1'b0;
        if (!iic_enable || iic_start_xfer) begin
            ecnt <= 0;
        end else if (iic_clock_en) begin
            if (ecnt == 5 && !mute) iic_xfer_done <= 1'b1;
            ecnt <= ecnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [23:0] frames[$];
    int          first_sx = -1;
    int          sx_fall  = 0;
    int          t_start  = 0;
    int          t_idle   = 0;
    int          ovl      = 0;
    int          viol     = 0;
    logic        sx_prev  = 1'b0;
    logic        en_prev  = 1'b0;
    logic [23:0] data_prev = '0;

    always @(negedge clock_in) begin
        if (iic_start_xfer && !sx_prev) begin
            frames.push_back(iic_data);
            if (first_sx < 0) first_sx = cyc;
        end
        if (iic_start_xfer && iic_clock_en) ovl++;
        if (!iic_start_xfer && sx_prev) begin
            chk("tick_overlap", 32'(ovl), 32'd1);
            ovl     = 0;
            sx_fall = cyc;
        end
        if (iic_enable && en_prev && iic_data != data_prev) viol++;
        sx_prev   = iic_start_xfer;
        en_prev   = iic_enable;
        data_prev = iic_data;
    end

    task automatic load(input logic [23:0] a, b, c, d);
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[3] = d;
    endtask

    task automatic pulse_start();
        @(negedge clock_in);
        start    = 1'b1;
        t_start  = cyc;
        first_sx = -1;
        @(negedge clock_in);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clock_in);
            n++;
        end
        t_idle = cyc;
        if (n >= budget) chk({tag, "_busy_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input string tag);
        frames.delete();
        pulse_start();
        wait_idle(tag, 5000);
    endtask

    initial begin
        reset_in = 1'b1;
        start    = 1'b0;
        load(24'h0, 24'h0, 24'h0, 24'h0);
        repeat (3) @(negedge clock_in);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_iic_data", 32'(iic_data), 32'd0);
        chk("rst_enable", 32'(iic_enable), 32'd0);
        chk("rst_start_xfer", 32'(iic_start_xfer), 32'd0);
        chk("rst_clock_en", 32'(iic_clock_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(init_err), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        reset_in = 1'b0;

        // Two writes then END
        load(24'h300A00, 24'h300B00, 24'hFFFFFF, 24'h000000);
        run("t1");
        chk("t1_frames", 32'(frames.size()), 32'd2);
        chk("t1_data0", 32'(frames[0]), 32'h300A00);
        chk("t1_data1", 32'(frames[1]), 32'h300B00);
        chk("t1_wr_count", 32'(wr_count), 32'd2);
        chk("t1_done", 32'(init_done), 32'd1);
        chk("t1_err", 32'(init_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_enable", 32'(iic_enable), 32'd0);
        chk("t1_rom_addr", 32'(rom_addr), 32'd2);

        // 5 ms delay (500 cycles) before the only write
        load(24'hFFFE05, 24'h010001, 24'hFFFFFF, 24'h000000);
        run("t2");
        chk("t2_wr_count", 32'(wr_count), 32'd1);
        chk("t2_data0", 32'(frames[0]), 32'h010001);
        chk("t2_dly_min", 32'((first_sx - t_start) >= 500), 32'd1);
        chk("t2_dly_max", 32'((first_sx - t_start) <= 520), 32'd1);
        chk("t2_done", 32'(init_done), 32'd1);

        // Engine silent: timeout after 255 ticks (~1020 cycles)
        mute = 1'b1;
        load(24'h123456, 24'hFFFFFF, 24'h000000, 24'h000000);
        run("t3");
        chk("t3_err", 32'(init_err), 32'd1);
        chk("t3_done", 32'(init_done), 32'd0);
        chk("t3_enable", 32'(iic_enable), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_wr_count", 32'(wr_count), 32'd0);
        chk("t3_tmo_min", 32'((t_idle - sx_fall) >= 1000), 32'd1);
        chk("t3_tmo_max", 32'((t_idle - sx_fall) <= 1040), 32'd1);
        mute = 1'b0;

        // No END marker: full 4-entry table, implicit end at last address
        load(24'h111111, 24'h222222, 24'h333333, 24'h444444);
        run("t4");
        chk("t4_frames", 32'(frames.size()), 32'd4);
        chk("t4_data3", 32'(frames[3]), 32'h444444);
        chk("t4_rom_addr", 32'(rom_addr), 32'd3);
        chk("t4_done", 32'(init_done), 32'd1);
        chk("t4_wr_count_wrap", 32'(wr_count), 32'd0);

        // Reset while waiting on the engine, then rerun
        mute = 1'b1;
        load(24'h300A00, 24'h300B00, 24'hFFFFFF, 24'h000000);
        frames.delete();
        pulse_start();
        begin
            int n = 0;
            while (!(frames.size() > 0 && !iic_start_xfer) && n < 200) begin
                @(negedge clock_in);
                n++;
            end
            if (n >= 200) chk("t5_reach_wait", 32'(frames.size()), 32'd1);
        end
        repeat (3) @(negedge clock_in);
        reset_in = 1'b1;
        #1;
        chk("t5_enable", 32'(iic_enable), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rom_addr", 32'(rom_addr), 32'd0);
        chk("t5_iic_data", 32'(iic_data), 32'd0);
        chk("t5_done", 32'(init_done), 32'd0);
        @(negedge clock_in);
        reset_in = 1'b0;
        mute     = 1'b0;
        run("t5b");
        chk("t5_rerun_data0", 32'(frames[0]), 32'h300A00);
        chk("t5_rerun_wr", 32'(wr_count), 32'd2);
        chk("t5_rerun_done", 32'(init_done), 32'd1);

        // Extra starts during a run are ignored
        frames.delete();
        pulse_start();
        repeat (30) @(negedge clock_in);
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        repeat (40) @(negedge clock_in);
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        wait_idle("t6", 5000);
        chk("t6_frames", 32'(frames.size()), 32'd2);
        chk("t6_data1", 32'(frames[1]), 32'h300B00);
        chk("t6_wr_count", 32'(wr_count), 32'd2);
        repeat (5) @(negedge clock_in);
        chk("t6_no_restart", 32'(busy), 32'd0);

        chk("data_stable", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
